// File: rtl/stitched_pipeline_stall.sv
// Ready/valid pipeline: NUM_STAGES combinational stages between NUM_STAGES+1 register ranks, with bubble collapsing.
// Optional registered occupancy output enabled by defining STITCHED_PIPELINE_OCCUPANCY_EN.
module stitched_pipeline_stall #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef STITCHED_PIPELINE_OCCUPANCY_EN
    ,
    output logic [$clog2(NUM_STAGES+2)-1:0] occupancy
`endif
);

    localparam int N = NUM_STAGES;
    localparam int W = DATA_WIDTH;

    logic [N:0]        valid_q;
    logic [N:0]        valid_d;
    logic [N:0]        load;
    logic [N:0][W-1:0] data_q;
    logic [N:0][W-1:0] data_nx;

    for (genvar k = 0; k <= N; k++) begin : g_rank
        logic [W-1:0] src;
        logic         src_valid;

        if (k == 0) begin : g_in
            assign src       = x;
            assign src_valid = in_valid;
        end else begin : g_stage
            if (((k - 1) % 2) == 0) begin : g_even
                assign src = data_q[k-1] + W'(1);
            end else begin : g_odd
                assign src = {data_q[k-1][W-1:1] + (W-1)'(1), data_q[k-1][0]};
            end
            assign src_valid = valid_q[k-1];
        end

        // Unrolled form of load_k = ~valid_k | load_{k+1}: a rank can load
        // whenever the consumer takes or any rank from here downstream is empty.
        assign load[k]    = out_ready | ~(&valid_q[N:k]);
        assign valid_d[k] = load[k] ? src_valid : valid_q[k];
        assign data_nx[k] = (load[k] && src_valid) ? src : data_q[k];
    end

    assign in_ready  = rst & load[0];
    assign out       = data_q[N];
    assign out_valid = valid_q[N];

    always_ff @(posedge clk) begin
        data_q <= data_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

`ifdef STITCHED_PIPELINE_OCCUPANCY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= ($clog2(NUM_STAGES+2))'($countones(valid_d));
        end
    end
`endif

endmodule

// File: tb/tb_stitched_pipeline_stall.sv
// Directed and scoreboard bench for stitched_pipeline_stall at (W=32,N=2), (W=8,N=1), (W=16,N=4).
// Occupancy checks are compiled in when STITCHED_PIPELINE_OCCUPANCY_EN is defined.
module tb_stitched_pipeline_stall;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        iv2, ir2, ov2, or2;
    logic [31:0] x2, o2;
    logic        iv1, ir1, ov1, or1;
    logic [7:0]  x1, o1;
    logic        iv4, ir4, ov4, or4;
    logic [15:0] x4, o4;
`ifdef STITCHED_PIPELINE_OCCUPANCY_EN
    logic [1:0]  oc2, oc1;
    logic [2:0]  oc4;
`endif

    stitched_pipeline_stall #(.DATA_WIDTH(32), .NUM_STAGES(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .x(x2),
        .out(o2), .out_valid(ov2), .out_ready(or2)
`ifdef STITCHED_PIPELINE_OCCUPANCY_EN
        , .occupancy(oc2)
`endif
    );

    stitched_pipeline_stall #(.DATA_WIDTH(8), .NUM_STAGES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .x(x1),
        .out(o1), .out_valid(ov1), .out_ready(or1)
`ifdef STITCHED_PIPELINE_OCCUPANCY_EN
        , .occupancy(oc1)
`endif
    );

    stitched_pipeline_stall #(.DATA_WIDTH(16), .NUM_STAGES(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .x(x4),
        .out(o4), .out_valid(ov4), .out_ready(or4)
`ifdef STITCHED_PIPELINE_OCCUPANCY_EN
        , .occupancy(oc4)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // A stalled valid output must keep its data and valid flag across the edge.
    always @(posedge clk) begin : hold_u2
        logic        h;
        logic [31:0] d;
        h = rst && ov2 && !or2;
        d = o2;
        #1;
        if (h) chk("hold_u2", {31'b0, ov2, o2}, {32'd1, d});
    end

    always @(posedge clk) begin : hold_u4
        logic        h;
        logic [15:0] d;
        h = rst && ov4 && !or4;
        d = o4;
        #1;
        if (h) chk("hold_u4", {47'b0, ov4, o4}, {48'd1, d});
    end

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    vec_t v2[5];
    vec_t v1[3];

    task automatic one2(input logic [31:0] xv, input logic [31:0] yv);
        or2 = 1'b1; iv2 = 1'b1; x2 = xv;
        #1;
        chk("one2_in_ready", 64'(ir2), 64'd1);
        tick; iv2 = 1'b0;
        chk("one2_lat_e0", 64'(ov2), 64'd0);
        tick;
        chk("one2_lat_e1", 64'(ov2), 64'd0);
        tick;
        chk("one2_valid", 64'(ov2), 64'd1);
        chk("one2_data", 64'(o2), 64'(yv));
        tick;
        chk("one2_single_cycle", 64'(ov2), 64'd0);
    endtask

    task automatic one1(input logic [7:0] xv, input logic [7:0] yv);
        or1 = 1'b1; iv1 = 1'b1; x1 = xv;
        #1;
        chk("one1_in_ready", 64'(ir1), 64'd1);
        tick; iv1 = 1'b0;
        chk("one1_lat_e0", 64'(ov1), 64'd0);
        tick;
        chk("one1_valid", 64'(ov1), 64'd1);
        chk("one1_data", 64'(o1), 64'(yv));
        tick;
        chk("one1_single_cycle", 64'(ov1), 64'd0);
    endtask

    logic [15:0] q[$];

    initial begin
        v2[0] = '{32'h0000_0005, 32'h0000_0008};
        v2[1] = '{32'hFFFF_FFFE, 32'h0000_0001};
        v2[2] = '{32'hFFFF_FFFF, 32'h0000_0002};
        v2[3] = '{32'h0000_0000, 32'h0000_0003};
        v2[4] = '{32'h7FFF_FFFE, 32'h8000_0001};
        v1[0] = '{32'h0000_00FF, 32'h0000_0000};
        v1[1] = '{32'h0000_0000, 32'h0000_0001};
        v1[2] = '{32'h0000_007F, 32'h0000_0080};

        iv2 = 1'b0; or2 = 1'b1; x2 = '0;
        iv1 = 1'b0; or1 = 1'b1; x1 = '0;
        iv4 = 1'b0; or4 = 1'b1; x4 = '0;

        // Reset state
        tick;
        chk("rst_ov2", 64'(ov2), 64'd0);
        chk("rst_ir2", 64'(ir2), 64'd0);
        chk("rst_ov1", 64'(ov1), 64'd0);
        chk("rst_ov4", 64'(ov4), 64'd0);
`ifdef STITCHED_PIPELINE_OCCUPANCY_EN
        chk("rst_occ2", 64'(oc2), 64'd0);
`endif
        tick;
        rst = 1'b1;
        #1;
        chk("post_rst_ir2", 64'(ir2), 64'd1);

        for (int unsigned i = 0; i < 5; i++) one2(v2[i].x, v2[i].y);
        for (int unsigned i = 0; i < 3; i++) one1(v1[i].x[7:0], v1[i].y[7:0]);

        // Back-to-back fill against a stalled consumer, then drain
        or2 = 1'b0; iv2 = 1'b1; x2 = 32'd1;
        #1; chk("b2b_rdy1", 64'(ir2), 64'd1);
        tick; x2 = 32'd2;
        #1; chk("b2b_rdy2", 64'(ir2), 64'd1);
        tick; x2 = 32'd3;
        #1; chk("b2b_rdy3", 64'(ir2), 64'd1);
        tick; x2 = 32'd4;
        #1;
        chk("b2b_full_rdy", 64'(ir2), 64'd0);
        chk("b2b_full_ov", 64'(ov2), 64'd1);
        chk("b2b_full_out", 64'(o2), 64'd4);
`ifdef STITCHED_PIPELINE_OCCUPANCY_EN
        chk("b2b_occ", 64'(oc2), 64'd3);
`endif
        repeat (2) begin
            tick;
            chk("b2b_stall_rdy", 64'(ir2), 64'd0);
            chk("b2b_stall_out", 64'(o2), 64'd4);
        end
        or2 = 1'b1;
        #1;
        chk("b2b_shift_rdy", 64'(ir2), 64'd1);
        tick; iv2 = 1'b0;
        chk("b2b_out5", {31'b0, ov2, o2}, {32'd1, 32'd5});
        tick;
        chk("b2b_out6", {31'b0, ov2, o2}, {32'd1, 32'd6});
        tick;
        chk("b2b_out7", {31'b0, ov2, o2}, {32'd1, 32'd7});
        tick;
        chk("b2b_empty", 64'(ov2), 64'd0);

        // Bubble collapse: A then B two cycles later under a 5-cycle stall
        or2 = 1'b0; iv2 = 1'b1; x2 = 32'h10;
        #1; chk("bub_rdyA", 64'(ir2), 64'd1);
        tick; iv2 = 1'b0;
        tick; iv2 = 1'b1; x2 = 32'h20;
        #1; chk("bub_rdyB", 64'(ir2), 64'd1);
        tick; iv2 = 1'b0;
        tick;
        chk("bub_rdy_free", 64'(ir2), 64'd1);
`ifdef STITCHED_PIPELINE_OCCUPANCY_EN
        chk("bub_occ", 64'(oc2), 64'd2);
`endif
        tick;
        or2 = 1'b1;
        #1;
        chk("bub_popA", {31'b0, ov2, o2}, {32'd1, 32'h13});
        tick;
        chk("bub_popB", {31'b0, ov2, o2}, {32'd1, 32'h23});
        tick;
        chk("bub_empty", 64'(ov2), 64'd0);

        // Reset with three items in flight
        or2 = 1'b0; iv2 = 1'b1; x2 = 32'h100;
        tick; x2 = 32'h200;
        tick; x2 = 32'h300;
        tick;
        rst = 1'b0; x2 = 32'h999;
        #1;
        chk("mid_rst_rdy", 64'(ir2), 64'd0);
        tick;
        rst = 1'b1; iv2 = 1'b0;
        chk("mid_rst_ov", 64'(ov2), 64'd0);
`ifdef STITCHED_PIPELINE_OCCUPANCY_EN
        chk("mid_rst_occ", 64'(oc2), 64'd0);
`endif
        or2 = 1'b1;
        repeat (5) begin
            tick;
            chk("mid_rst_no_stale", 64'(ov2), 64'd0);
        end

        // Random traffic against an in-order scoreboard (N=4 adds 6)
        for (int c = 0; c < 10000; c++) begin
            iv4 = 1'($urandom_range(0, 1));
            x4  = 16'($urandom);
            or4 = 1'($urandom_range(0, 1));
            #1;
            if (ov4 && or4) begin
                if (q.size() == 0) chk("rand_spurious", 64'd1, 64'd0);
                else chk("rand_data", 64'(o4), 64'(q.pop_front()));
            end
            if (iv4 && ir4) q.push_back(x4 + 16'd6);
            tick;
`ifdef STITCHED_PIPELINE_OCCUPANCY_EN
            chk("rand_occ", 64'(oc4), 64'(q.size()));
`endif
        end
        iv4 = 1'b0; or4 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (ov4) begin
                if (q.size() == 0) chk("drain_spurious", 64'd1, 64'd0);
                else chk("drain_data", 64'(o4), 64'(q.pop_front()));
            end
            tick;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stitched_pipeline_stall.md
Name: stitched_pipeline_stall

Overview:
- Parametrised successor to the two-stage stitched valid pipeline wrapper.
- Chains NUM_STAGES combinational stage functions between NUM_STAGES+1 register ranks.
- Adds ready/valid backpressure with bubble collapsing, so a downstream consumer can stall the pipeline without losing or duplicating items.
- Sits between a producer and consumer that both speak valid/ready.

Parameters:
- DATA_WIDTH, 32: width of data in, data out and every pipeline register; must be >= 2.
- NUM_STAGES, 2: number of combinational stages; must be >= 1. Register ranks p0..pNUM_STAGES, so NUM_STAGES+1 ranks in total.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- in_valid  input  1  producer presents x this cycle.
- in_ready  output  1  pipeline accepts x this cycle.
- x  input  DATA_WIDTH  input data.
- out  output  DATA_WIDTH  result, driven directly from register rank pNUM_STAGES.
- out_valid  output  1  out holds a valid item.
- out_ready  input  1  consumer accepts out this cycle.

Behaviour:
- Stage functions, for stage i (0-based), all arithmetic modulo 2^DATA_WIDTH with no carry out:
  - Even i: out = in + 1.
  - Odd i: out = {in[W-1:1] + 1, in[0]}, which is equivalent to in + 2 with bit 0 preserved.
  - End-to-end result: x + (ceil(N/2) + 2*floor(N/2)) mod 2^W. This is +3 for N=2, +4 for N=3, +1 for N=1.
- Rank p0 holds the input. Rank pk (k >= 1) holds the output of stage k-1 applied to rank pk-1.
- Each rank has a data register and a valid bit.
- Advance rule: load_k = ~valid_k | take_k, where:
  - take_N = out_ready.
  - take_k = load_{k+1} for k < N.
- in_ready = load_0 while rst=1. in_ready is forced 0 while rst=0.
- Accepted transfer: in_valid & in_ready. On a transfer, p0 captures x and valid_0 is set.
- When load_0 & ~in_valid, valid_0 clears.
- For k >= 1, when load_k holds: data_k <= stage_{k-1}(data_{k-1}) and valid_k <= valid_{k-1}.
- Data registers change only when they load with a valid source. Otherwise they hold their value; there is no X injection and no clear.
- Bubble collapsing: an empty rank loads even while downstream is stalled, so bubbles are squeezed out.
- Latency:
  - With out_ready held 1, an item accepted at edge T appears with out_valid=1 after edge T+N, i.e. N+1 rising edges including capture.
  - Throughput is one item per cycle.
- out_valid=1 with out_ready=0: out and out_valid hold stable until accepted. This is a required bench assertion.
- Full pipeline (all N+1 ranks valid) with out_ready=0: in_ready=0, and no rank changes.
- Full pipeline with out_ready=1: every rank shifts and in_ready=1 in the same cycle. There is no bubble penalty.
- Order is strictly FIFO. Capacity is exactly N+1 items.
- Reset:
  - Reset edge (rst=0): all valid bits go to 0, so out_valid=0 from the next cycle.
  - Data register contents are don't-care after reset and are not cleared.
  - Reset mid-operation discards all in-flight items. No item accepted before reset emerges afterwards.
- Ready is combinational from out_ready through all ranks to in_ready. No combinational path exists from in_valid to in_ready.

Optional Feature:
- Macro: STITCHED_PIPELINE_OCCUPANCY_EN.
- When defined, the block adds output port occupancy, width $clog2(NUM_STAGES+2), registered:
  - Count of set valid bits, updated every edge.
  - Reset value 0.
  - Range 0..N+1.
  - Must equal accepted inputs minus accepted outputs since reset.
- When undefined, the port and its logic are absent. Data and handshake behaviour are identical in both builds.

Test Plan:
- Defaults (W=32, N=2), out_ready=1, one transfer with x=0x00000005 -> out=0x00000008, out_valid=1 for exactly one cycle, 3 edges after acceptance.
- Wrap-around, x=0xFFFFFFFE -> out=0x00000001. Then N=1, W=8, x=0xFF -> out=0x00.
- Back-to-back x=1,2,3,4 with out_ready=0 -> in_ready drops after 3 items accepted, x=4 held. Then raise out_ready -> outputs 4,5,6,7 in order on consecutive cycles, with no drop and no duplicate.
- Bubble collapse: accept item A, stall out_ready=0 for 5 cycles, feed item B two cycles later -> A and B occupy adjacent ranks and pop on consecutive cycles once out_ready=1.
- Drive rst=0 for 1 cycle with 3 items in flight -> out_valid=0 the next cycle, in_ready=0 during reset, and no stale item emerges afterwards. With the macro defined, occupancy = 0.
- Random valid/ready over 10k cycles, N=4, W=16 -> scoreboard matches x+6 mod 2^16 in order. With the macro defined, occupancy equals scoreboard depth every cycle.
